// File: rtl/register_file_mp_if.sv
// Bus between decode/writeback (master) and the multi-port register file (slave).
// Carries the read, write and reservation ports and the scoreboard debug vector.
interface register_file_mp_if #(
  parameter int NBITS      = 32,
  parameter int NREGISTERS = 32,
  parameter int ADDR_W     = 5,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 1
);
  logic                       ENABLE;
  logic [NREAD-1:0]           RD;
  logic [NREAD*ADDR_W-1:0]    ADD_RD;
  logic [NREAD*NBITS-1:0]     OUT;
  logic [NREAD-1:0]           BUSY;
  logic [NWRITE-1:0]          WR;
  logic [NWRITE*ADDR_W-1:0]   ADD_WR;
  logic [NWRITE*NBITS-1:0]    DATAIN;
  logic                       RSV;
  logic [ADDR_W-1:0]          ADD_RSV;
  logic [NREGISTERS-1:0]      PENDING;

  modport master (
    output ENABLE, RD, ADD_RD, WR, ADD_WR, DATAIN, RSV, ADD_RSV,
    input  OUT, BUSY, PENDING
  );

  modport slave (
    input  ENABLE, RD, ADD_RD, WR, ADD_WR, DATAIN, RSV, ADD_RSV,
    output OUT, BUSY, PENDING
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file with pending scoreboard and ENABLE-gated registered reads.
// Optional macro RF_BYPASS_EN forwards same-cycle write data (and post-write busy) to reads.
module register_file_mp #(
  parameter int NBITS      = 32,
  parameter int NREGISTERS = 32,
  parameter int ADDR_W     = 5,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 1,
  parameter int ZERO_REG   = 1
) (
  input logic               CLK,
  input logic               RESET,
  register_file_mp_if.slave bus
);

  logic [NBITS-1:0]            r_regs [NREGISTERS];
  logic [NREGISTERS-1:0]       r_pending;
  logic [NREAD-1:0][NBITS-1:0] r_out;
  logic [NREAD-1:0]            r_busy;

  logic [NREGISTERS-1:0]       w_wr_hit;
  logic [NBITS-1:0]            w_wr_data [NREGISTERS];
  logic [NREGISTERS-1:0]       w_rsv_hit;
  logic [NREGISTERS-1:0]       w_pending_nxt;
  logic [NREAD-1:0][NBITS-1:0] w_rd_data;
  logic [NREAD-1:0]            w_rd_busy;

  // Register 0 is hardwired when ZERO_REG is set: never written, reserved or read.
  function automatic logic is_dropped(input int r);
    return (ZERO_REG != 0) && (r == 0);
  endfunction

  // Per-register write decode; ascending port scan lets the highest-index writer win.
  // Addresses >= NREGISTERS match no register and are therefore ignored.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    for (int r = 0; r < NREGISTERS; r++) begin
      w_wr_hit[r]  = 1'b0;
      w_wr_data[r] = '0;
      w_rsv_hit[r] = bus.RSV && (bus.ADD_RSV == ADDR_W'(r)) && !is_dropped(r);
      for (int w = 0; w < NWRITE; w++) begin
        if (bus.WR[w] && (bus.ADD_WR[w*ADDR_W +: ADDR_W] == ADDR_W'(r)) && !is_dropped(r)) begin
          w_wr_hit[r]  = 1'b1;
          w_wr_data[r] = bus.DATAIN[w*NBITS +: NBITS];
        end
      end
    end
  end

  // A reservation in the same cycle as a write wins: a new producer is in flight.
  always_comb begin
    w_pending_nxt = r_pending;
    for (int r = 0; r < NREGISTERS; r++) begin
      if (w_rsv_hit[r]) begin
        w_pending_nxt[r] = 1'b1;
      end else if (w_wr_hit[r]) begin
        w_pending_nxt[r] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      w_rd_data[p] = '0;
      w_rd_busy[p] = 1'b0;
      if (bus.RD[p]) begin
        for (int r = 0; r < NREGISTERS; r++) begin
          if ((bus.ADD_RD[p*ADDR_W +: ADDR_W] == ADDR_W'(r)) && !is_dropped(r)) begin
`ifdef RF_BYPASS_EN
            if (w_wr_hit[r]) begin
              w_rd_data[p] = w_wr_data[r];
              w_rd_busy[p] = w_rsv_hit[r];
            end else begin
              w_rd_data[p] = r_regs[r];
              w_rd_busy[p] = r_pending[r];
            end
`else
            w_rd_data[p] = r_regs[r];
            w_rd_busy[p] = r_pending[r];
`endif
          end
        end
      end
    end
  end

  // NOTE: the array is reset because architectural state must read as zero after RESET;
  // sequential state uses non-blocking assignments so all regs update from pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int r = 0; r < NREGISTERS; r++) begin
        r_regs[r] <= '0;
      end
      r_pending <= '0;
    end else begin
      for (int r = 0; r < NREGISTERS; r++) begin
        if (w_wr_hit[r]) begin
          r_regs[r] <= w_wr_data[r];
        end
      end
      r_pending <= w_pending_nxt;
    end
  end

  // ENABLE gates only the read stage; writes and reservations proceed regardless.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_out  <= '0;
      r_busy <= '0;
    end else if (bus.ENABLE) begin
      r_out  <= w_rd_data;
      r_busy <= w_rd_busy;
    end
  end

  assign bus.OUT     = r_out;
  assign bus.BUSY    = r_busy;
  assign bus.PENDING = r_pending;

endmodule

// File: tb/tb_register_file_mp.sv
// Directed-vector bench for register_file_mp (2 read, 2 write ports, 24 registers, zero reg).
// Bypass expectations follow RF_BYPASS_EN when the bench is built with it.
module tb_register_file_mp;
  localparam int NBITS      = 32;
  localparam int NREGISTERS = 24;
  localparam int ADDR_W     = 5;
  localparam int NREAD      = 2;
  localparam int NWRITE     = 2;
  localparam int ZERO_REG   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  register_file_mp_if #(
    .NBITS(NBITS), .NREGISTERS(NREGISTERS), .ADDR_W(ADDR_W),
    .NREAD(NREAD), .NWRITE(NWRITE)
  ) bus ();

  register_file_mp #(
    .NBITS(NBITS), .NREGISTERS(NREGISTERS), .ADDR_W(ADDR_W),
    .NREAD(NREAD), .NWRITE(NWRITE), .ZERO_REG(ZERO_REG)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ENABLE  = 1'b0;
    bus.RD      = '0;
    bus.ADD_RD  = '0;
    bus.WR      = '0;
    bus.ADD_WR  = '0;
    bus.DATAIN  = '0;
    bus.RSV     = 1'b0;
    bus.ADD_RSV = '0;
  endtask

  task automatic wr(input int port, input logic [ADDR_W-1:0] a, input logic [NBITS-1:0] d);
    bus.WR[port]                     = 1'b1;
    bus.ADD_WR[port*ADDR_W +: ADDR_W] = a;
    bus.DATAIN[port*NBITS +: NBITS]  = d;
  endtask

  task automatic rd(input int port, input logic [ADDR_W-1:0] a);
    bus.ENABLE                        = 1'b1;
    bus.RD[port]                      = 1'b1;
    bus.ADD_RD[port*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic rsv(input logic [ADDR_W-1:0] a);
    bus.RSV     = 1'b1;
    bus.ADD_RSV = a;
  endtask

  function automatic logic [NBITS-1:0] out_of(input int port);
    return bus.OUT[port*NBITS +: NBITS];
  endfunction

  logic [NBITS-1:0] exp_byp_out;
  logic             exp_byp_busy;

  initial begin
    idle();
    #1;
    check("reset_pending", 64'(bus.PENDING), 64'h0);
    check("reset_out", 64'(bus.OUT), 64'h0);
    tick();
    tick();
    rst = 1'b0;

    // Build some state, then assert reset between edges.
    idle(); wr(0, 5'd5, 32'h77); rsv(5'd6); tick();
    idle(); rd(0, 5'd5); rd(1, 5'd6); tick();
    check("pre_rst_out0", 64'(out_of(0)), 64'h77);
    check("pre_rst_busy1", 64'(bus.BUSY[1]), 64'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", 64'(bus.OUT), 64'h0);
    check("mid_rst_busy", 64'(bus.BUSY), 64'h0);
    check("mid_rst_pending", 64'(bus.PENDING), 64'h0);
    #1 rst = 1'b0;
    idle(); rd(0, 5'd5); tick();
    check("post_rst_r5", 64'(out_of(0)), 64'h0);

    // Basic write/read, ENABLE hold, RD=0 clears.
    idle(); wr(0, 5'd3, 32'hDEADBEEF); tick();
    idle(); rd(0, 5'd3); tick();
    check("rd_r3", 64'(out_of(0)), 64'hDEADBEEF);
    idle(); bus.RD[0] = 1'b1; bus.ADD_RD[4:0] = 5'd5; tick();
    check("hold_r3", 64'(out_of(0)), 64'hDEADBEEF);
    idle(); bus.ENABLE = 1'b1; tick();
    check("rd_off_zero", 64'(out_of(0)), 64'h0);

    // Zero register: write and reservation dropped.
    idle(); wr(0, 5'd0, 32'h1234); rsv(5'd0); tick();
    check("zero_pending", 64'(bus.PENDING[0]), 64'h0);
    idle(); rd(0, 5'd0); rd(1, 5'd3); tick();
    check("zero_out", 64'(out_of(0)), 64'h0);
    check("zero_busy", 64'(bus.BUSY[0]), 64'h0);
    check("port1_r3", 64'(out_of(1)), 64'hDEADBEEF);

    // Write conflict: port 1 wins; then independent writes on both ports.
    idle(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); tick();
    idle(); wr(0, 5'd8, 32'h33); wr(1, 5'd10, 32'h44); rd(0, 5'd7); tick();
    check("conflict_r7", 64'(out_of(0)), 64'h22);
    idle(); rd(0, 5'd8); rd(1, 5'd10); tick();
    check("dual_r8", 64'(out_of(0)), 64'h33);
    check("dual_r10", 64'(out_of(1)), 64'h44);

    // Scoreboard.
    idle(); rsv(5'd9); tick();
    check("rsv_pend9", 64'(bus.PENDING), 64'h200);
    idle(); rd(0, 5'd9); tick();
    check("rsv_busy9", 64'(bus.BUSY[0]), 64'h1);
    idle(); wr(0, 5'd9, 32'h55); tick();
    check("wr_clr9", 64'(bus.PENDING[9]), 64'h0);
    idle(); rd(0, 5'd9); tick();
    check("wr_out9", 64'(out_of(0)), 64'h55);
    check("wr_busy9", 64'(bus.BUSY[0]), 64'h0);
    idle(); wr(1, 5'd9, 32'h66); rsv(5'd9); tick();
    check("rsv_wins9", 64'(bus.PENDING[9]), 64'h1);
    idle(); rd(0, 5'd9); tick();
    check("rsv_wr_out9", 64'(out_of(0)), 64'h66);
    check("rsv_wr_busy9", 64'(bus.BUSY[0]), 64'h1);

    // Out-of-range address: write/reserve ignored, read returns zero.
    idle(); wr(0, 5'd30, 32'hAB); rsv(5'd30); rd(0, 5'd3); tick();
    check("oor_pending", 64'(bus.PENDING), 64'h200);
    idle(); rd(0, 5'd30); tick();
    check("oor_out", 64'(out_of(0)), 64'h0);
    check("oor_busy", 64'(bus.BUSY[0]), 64'h0);

    // Same-cycle write and read of r4.
    idle(); wr(0, 5'd4, 32'hA); tick();
    idle(); wr(0, 5'd4, 32'hB); rd(0, 5'd4); tick();
`ifdef RF_BYPASS_EN
    exp_byp_out = 32'hB;
`else
    exp_byp_out = 32'hA;
`endif
    check("byp_out", 64'(out_of(0)), 64'(exp_byp_out));
    check("byp_busy", 64'(bus.BUSY[0]), 64'h0);
    idle(); wr(1, 5'd4, 32'hC); rsv(5'd4); rd(0, 5'd4); tick();
`ifdef RF_BYPASS_EN
    exp_byp_out  = 32'hC;
    exp_byp_busy = 1'b1;
`else
    exp_byp_out  = 32'hB;
    exp_byp_busy = 1'b0;
`endif
    check("byp_rsv_out", 64'(out_of(0)), 64'(exp_byp_out));
    check("byp_rsv_busy", 64'(bus.BUSY[0]), 64'(exp_byp_busy));
    idle(); rd(1, 5'd4); tick();
    check("after_byp_out", 64'(out_of(1)), 64'hC);
    check("after_byp_busy", 64'(bus.BUSY[1]), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised multi-port successor to the decode-stage register file.
- Configurable read/write port counts, hardwired zero register, per-register pending (scoreboard) bits, ENABLE-gated registered reads.
- Sits in decode; feeds operands and per-operand busy flags to the issue/hazard logic.
- Writeback drives the write ports; decode drives the reservation port.

Parameters:
NBITS, 32, data width
NREGISTERS, 32, number of architectural registers
ADDR_W, 5, address width; must satisfy 2**ADDR_W >= NREGISTERS
NREAD, 2, number of read ports
NWRITE, 1, number of write ports
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes/reservations

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
ENABLE  in  1  read-stage enable; gates read-port updates only
RD  in  NREAD  per-port read strobe
ADD_RD  in  NREAD*ADDR_W  read addresses; port p at [p*ADDR_W +: ADDR_W]
OUT  out  NREAD*NBITS  read data; port p at [p*NBITS +: NBITS]
BUSY  out  NREAD  pending flag of the register read on port p
WR  in  NWRITE  per-port write strobe
ADD_WR  in  NWRITE*ADDR_W  write addresses
DATAIN  in  NWRITE*NBITS  write data
RSV  in  1  reserve strobe: mark ADD_RSV pending
ADD_RSV  in  ADDR_W  register to reserve
PENDING  out  NREGISTERS  full scoreboard vector, for debug/stall logic

Behaviour:
- Reset (async, while RESET=1): all registers = 0, OUT = 0, BUSY = 0, PENDING = 0.
- Writes: on CLK rising edge, each port w with WR[w]=1 and in-range address updates REGISTERS[ADD_WR[w]]. Writes are not gated by ENABLE.
- Write conflict (two ports, same address, same cycle): highest-index port wins.
- Reads: 1-cycle latency. On a rising edge with ENABLE=1:
  - RD[p]=1: OUT[p] <= register value, BUSY[p] <= PENDING bit.
  - RD[p]=0: OUT[p] <= 0, BUSY[p] <= 0.
- ENABLE=0: OUT and BUSY hold their previous values.
- Read of a register written in the same cycle returns the OLD value (no bypass) unless RF_BYPASS_EN is defined.
- Scoreboard:
  - Any write to register r clears PENDING[r].
  - RSV=1 sets PENDING[ADD_RSV].
  - Reserve and write to the same register in the same cycle: reserve wins, bit ends set (a new producer is in flight).
  - BUSY samples PENDING before the edge's updates.
- ZERO_REG=1: writes to register 0 are dropped; reservations of register 0 are dropped; reads of register 0 give OUT=0, BUSY=0.
- Address >= NREGISTERS:
  - Write or reserve: ignored.
  - Read: OUT=0, BUSY=0.
- Reset asserted mid-operation: all state clears immediately. The first edge after deassertion behaves as a normal cycle.

Optional Feature:
Macro: RF_BYPASS_EN
- Defined: a read port whose address matches an active write port in the same cycle captures DATAIN of the winning (highest-index) writer instead of the array value. BUSY for that port reflects the post-write scoreboard: 0, unless RSV targets the same register that cycle.
- Bypass never applies to register 0 when ZERO_REG=1.
- Not defined: reads return pre-write array contents and pre-edge PENDING.

Test Plan:
1. Reset values: assert RESET mid-cycle, no clock edge -> OUT=0, BUSY=0, PENDING=0 immediately. After release, read r5 -> OUT=0.
2. Basic write/read: write r3=0xDEADBEEF, next cycle ENABLE=1, RD[0]=1, ADD_RD[0]=3 -> OUT[0]=0xDEADBEEF one cycle later. Drop ENABLE and change address -> OUT[0] holds.
3. Zero register: ZERO_REG=1, write r0=0x1234 and RSV r0 -> read r0 gives OUT=0, BUSY=0, PENDING[0]=0.
4. Write conflict: NWRITE=2, both ports write r7 (0x11 on port 0, 0x22 on port 1) -> read r7 = 0x22.
5. Scoreboard: RSV r9 -> next read BUSY=1, PENDING[9]=1. Write r9=0x55 -> PENDING[9]=0. RSV and WR on r9 in the same cycle -> PENDING[9]=1.
6. Bypass: r4=0xA, same cycle WR r4=0xB and read r4 -> OUT=0xB with RF_BYPASS_EN defined, OUT=0xA without it.
